// File: rtl/apb3_req_pkg.sv
// Shared types for the APB3 command requester: transfer FSM states and the
// response record handed back on the response channel.
package apb3_req_pkg;

  localparam int unsigned CountWidth = 16;
  // Widest data bus the response record can carry; narrower buses zero-extend.
  localparam int unsigned RspDataMax = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } req_state_e;

  typedef struct packed {
    logic [RspDataMax-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  function automatic rsp_t make_rsp(input logic [RspDataMax-1:0] rdata,
                                    input logic err,
                                    input logic timeout);
    rsp_t r;
    r.rdata   = rdata;
    r.err     = err;
    r.timeout = timeout;
    return r;
  endfunction

endpackage

// File: rtl/apb3_req_timer.sv
// ACCESS-phase watchdog: counts ACCESS cycles; expired is high during the
// TimeoutCycles-th ACCESS cycle of the current transfer.
module apb3_req_timer
  import apb3_req_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CountWidth-1:0] LastCount = CountWidth'(TimeoutCycles - 32'd1);

  logic [CountWidth-1:0] count_r;

  // Cycle counter, saturating at the last allowed ACCESS cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_r <= {CountWidth{1'b0}};
    end else if (clear) begin
      count_r <= {CountWidth{1'b0}};
    end else if (enable && (count_r != LastCount)) begin
      count_r <= count_r + CountWidth'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LastCount);

endmodule

// File: rtl/apb3_cmd_requester.sv
// Single-outstanding APB3 requester: accepts one command, runs the
// SETUP/ACCESS phases with a wait-state watchdog, and returns one response.
module apb3_cmd_requester
  import apb3_req_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic                 cmd_write_i,
  input  logic [DataWidth-1:0] cmd_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  output logic [AddrWidth-1:0] PADDR,
  output logic [DataWidth-1:0] PWDATA,
  output logic                 PWRITE,
  output logic                 PSEL,
  output logic                 PENABLE,
  input  logic [DataWidth-1:0] PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  req_state_e            state_r;
  logic                  cmd_ready_r;
  logic                  psel_r;
  logic                  penable_r;
  logic                  pwrite_r;
  logic [AddrWidth-1:0]  paddr_r;
  logic [DataWidth-1:0]  pwdata_r;
  logic                  rsp_valid_r;
  rsp_t                  rsp_r;

  logic                  handshake_s;
  logic                  timer_enable_s;
  logic                  timer_expired_s;
  logic [RspDataMax-1:0] prdata_ext_s;
  logic                  unused_rdata_s;

  assign handshake_s    = (state_r == IDLE) && cmd_valid_i && cmd_ready_r;
  assign timer_enable_s = (state_r == ACCESS);
  assign prdata_ext_s   = RspDataMax'(PRDATA);

  apb3_req_timer #(
    .TimeoutCycles (TimeoutCycles)
  ) u_timer (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .clear   (handshake_s),
    .enable  (timer_enable_s),
    .expired (timer_expired_s)
  );

  // Transfer FSM with all bus and response outputs registered.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {AddrWidth{1'b0}};
      pwdata_r    <= {DataWidth{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_r       <= make_rsp({RspDataMax{1'b0}}, 1'b0, 1'b0);
    end else begin
      case (state_r)
        IDLE: begin
          if (handshake_s) begin
            paddr_r     <= cmd_addr_i;
            pwrite_r    <= cmd_write_i;
            pwdata_r    <= cmd_write_i ? cmd_wdata_i : {DataWidth{1'b0}};
            psel_r      <= 1'b1;
            penable_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
            state_r     <= SETUP;
          end else begin
            // Also raises ready on the first cycle after reset release.
            cmd_ready_r <= 1'b1;
          end
        end
        SETUP: begin
          penable_r <= 1'b1;
          state_r   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_r       <= make_rsp(pwrite_r ? {RspDataMax{1'b0}} : prdata_ext_s,
                                    PSLVERR, 1'b0);
            state_r     <= RESP;
          end else if (timer_expired_s) begin
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_r       <= make_rsp({RspDataMax{1'b0}}, 1'b1, 1'b1);
            state_r     <= RESP;
          end else begin
            state_r <= ACCESS;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign unused_rdata_s = ^rsp_r.rdata;

  assign cmd_ready_o   = cmd_ready_r;
  assign PSEL          = psel_r;
  assign PENABLE       = penable_r;
  assign PWRITE        = pwrite_r;
  assign PADDR         = paddr_r;
  assign PWDATA        = pwdata_r;
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_rdata_o   = rsp_r.rdata[DataWidth-1:0];
  assign rsp_err_o     = rsp_r.err;
  assign rsp_timeout_o = rsp_r.timeout;

endmodule

// File: doc/apb3_cmd_requester.md
APB3_CMD_REQUESTER -- requirements
Module: apb3_cmd_requester

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, meaning APB address width.
REQ-002 SHALL have parameter DataWidth, default 32, meaning APB data width.
REQ-003 SHALL have parameter TimeoutCycles, default 256, meaning max ACCESS cycles before abort (range 1..65535).
REQ-004 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port RSTN  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports cmd_valid_i in 1, cmd_ready_o out 1, cmd_addr_i in AddrWidth, cmd_write_i in 1, cmd_wdata_i in DataWidth: command channel.
REQ-007 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_rdata_o out DataWidth, rsp_err_o out 1, rsp_timeout_o out 1: response channel.
REQ-008 SHALL have ports PADDR out AddrWidth, PWDATA out DataWidth, PWRITE out 1, PSEL out 1, PENABLE out 1, PRDATA in DataWidth, PREADY in 1, PSLVERR in 1: APB3 requester side.

Function
REQ-009 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-010 SHALL assert cmd_ready_o only in IDLE; handshake = cmd_valid_i & cmd_ready_o.
REQ-011 SHALL, on handshake in cycle N, register addr/write/wdata and enter SETUP at N+1 (PSEL=1, PENABLE=0).
REQ-012 SHALL enter ACCESS at N+2 (PSEL=1, PENABLE=1); PADDR/PWDATA/PWRITE stable from SETUP until ACCESS completes.
REQ-013 SHALL complete ACCESS in the cycle PREADY=1: capture PRDATA (reads only; writes return 0) and PSLVERR, drop PSEL/PENABLE next cycle, enter RESP.
REQ-014 SHALL give minimum latency handshake-to-rsp_valid_o of 3 cycles (zero-wait-state completer).
REQ-015 SHALL hold rsp_valid_o and response fields stable in RESP until rsp_ready_i=1, then return to IDLE next cycle.
REQ-016 SHALL count ACCESS cycles with a 16-bit counter cleared on SETUP entry; if PREADY=0 in the TimeoutCycles-th ACCESS cycle, abort: deassert PSEL/PENABLE, enter RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-017 SHALL, when PREADY=1 in the TimeoutCycles-th ACCESS cycle, complete normally (PREADY wins over timeout).
REQ-018 SHALL drive rsp_err_o = captured PSLVERR and rsp_timeout_o=0 on normal completion.
REQ-019 SHALL ignore PREADY, PSLVERR, PRDATA outside ACCESS.
REQ-020 SHALL ignore cmd_valid_i while not in IDLE; no command queuing (one outstanding transfer).
REQ-021 SHALL drive PWDATA=0 on reads; PADDR/PWDATA/PWRITE hold last value in IDLE/RESP.

Reset
REQ-022 SHALL, on RSTN=0 (asynchronously, including mid-transfer), enter IDLE and drive PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, cmd_ready_o=0 during reset, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0, counter=0.
REQ-023 SHALL assert cmd_ready_o in the first cycle after RSTN deasserts; an in-flight transfer is discarded with no response.

Structure
REQ-024 SHALL place the FSM state enum (IDLE, SETUP, ACCESS, RESP) and a response struct (rdata, err, timeout) in shared package apb3_req_pkg.
REQ-025 SHALL implement the timeout counter as sub-module apb3_req_timer (clear, enable, expired output); no other sub-modules.

Verification
REQ-026 Write addr 0x0000_0004 data 0x0000_00A5, PREADY tied 1 -> PSEL at N+1, PENABLE at N+2, PWRITE=1, rsp_valid_o at N+3, err=0, timeout=0, rdata=0.
REQ-027 Read addr 0x0000_0000, completer inserts 3 wait states, PRDATA=0xDEAD_BEEF -> ACCESS lasts 4 cycles, rsp_rdata_o=0xDEAD_BEEF, err=0.
REQ-028 Read with PSLVERR=1 on completion -> rsp_err_o=1, rsp_timeout_o=0.
REQ-029 TimeoutCycles=8, PREADY held 0 -> abort after 8th ACCESS cycle, rsp_err_o=1, rsp_timeout_o=1, rdata=0; PREADY=1 exactly in 8th cycle -> normal completion.
REQ-030 Response backpressure: rsp_ready_i low 5 cycles -> rsp fields stable, cmd_ready_o=0 throughout; new cmd_valid_i ignored until IDLE.
REQ-031 RSTN asserted during ACCESS -> PSEL/PENABLE fall asynchronously, no rsp_valid_o, cmd_ready_o=1 first cycle after release.
